// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the IF/ID and ID/EX registers of a 5-stage MIPS pipeline.
// Handles load-use bubbles, taken-branch flushes, multi-cycle EX freezes and a stall counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned MC_LATENCY  = 3,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [4:0]             ID_Rs,
    input  logic [4:0]             ID_Rt,
    input  logic                   ID_UsesRt,
    input  logic                   ID_BranchTaken,
    input  logic                   ID_MultiCycle,
    input  logic                   EX_MemRead,
    input  logic [4:0]             EX_DestReg,
    output logic                   PCWrite,
    output logic                   IFID_Write,
    output logic                   IFID_Flush,
    output logic                   IDEX_Flush,
    output logic                   IDEX_Hold,
    output logic                   EXMEM_Bubble,
    output logic                   Busy,
    output logic [STALL_CNT_W-1:0] StallCount
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LATENCY - 1);
    localparam bit MC_EN = (MC_LATENCY > 1);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    typedef enum logic {
        RUN,
        MC_BUSY
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;

    logic lu;
    logic pc_write_raw;
    logic ifid_write_raw;
    logic ifid_flush_raw;
    logic idex_flush_raw;
    logic idex_hold_raw;
    logic exmem_bubble_raw;
    logic busy_raw;

    assign lu = EX_MemRead && (EX_DestReg != 5'd0) &&
                ((EX_DestReg == ID_Rs) || (ID_UsesRt && (EX_DestReg == ID_Rt)));

    // State and countdown register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state and pipeline control decode
    always_comb begin
        state_nx         = state;
        cnt_nx           = cnt;
        pc_write_raw     = 1'b1;
        ifid_write_raw   = 1'b1;
        ifid_flush_raw   = 1'b0;
        idex_flush_raw   = 1'b0;
        idex_hold_raw    = 1'b0;
        exmem_bubble_raw = 1'b0;
        busy_raw         = 1'b0;
        case (state)
            RUN: begin
                if (lu) begin
                    // Load must reach MEM before its consumer can leave ID
                    pc_write_raw   = 1'b0;
                    ifid_write_raw = 1'b0;
                    idex_flush_raw = 1'b1;
                end else begin
                    if (ID_BranchTaken) begin
                        ifid_flush_raw = 1'b1;
                    end
                    if (ID_MultiCycle && MC_EN) begin
                        state_nx = MC_BUSY;
                        cnt_nx   = CNT_LOAD;
                    end
                end
            end
            MC_BUSY: begin
                pc_write_raw     = 1'b0;
                ifid_write_raw   = 1'b0;
                idex_hold_raw    = 1'b1;
                exmem_bubble_raw = 1'b1;
                busy_raw         = 1'b1;
                cnt_nx           = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nx = RUN;
                end
            end
            default: begin
                state_nx = RUN;
                cnt_nx   = '0;
            end
        endcase
    end

    // While reset is held the controller presents the plain running values
    assign PCWrite      = pc_write_raw   | Rst;
    assign IFID_Write   = ifid_write_raw | Rst;
    assign IFID_Flush   = ifid_flush_raw   & ~Rst;
    assign IDEX_Flush   = idex_flush_raw   & ~Rst;
    assign IDEX_Hold    = idex_hold_raw    & ~Rst;
    assign EXMEM_Bubble = exmem_bubble_raw & ~Rst;
    assign Busy         = busy_raw         & ~Rst;

    // Saturating stall-cycle counter
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            StallCount <= '0;
        end else if (!pc_write_raw && (StallCount != STALL_MAX)) begin
            StallCount <= StallCount + STALL_CNT_W'(1);
        end
    end

endmodule
